// File: rtl/mips_pkg.sv
// Shared MIPS definitions: load opcodes, load-kind encoding and the opcode decoder.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5
    } ld_kind_e;

    function automatic ld_kind_e load_kind(input logic [5:0] op);
        ld_kind_e k;
        case (op)
            OP_LB:   k = LD_B;
            OP_LBU:  k = LD_BU;
            OP_LH:   k = LD_H;
            OP_LHU:  k = LD_HU;
            OP_LW:   k = LD_W;
            default: k = LD_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational little-endian sub-word load alignment with sign/zero extension.
// Shared with the forwarding path, so it carries no state.
module load_align
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  ld_kind_e              kind_i,
    input  logic     [OFF_W-1:0]  off_i,
    input  logic     [XLEN-1:0]   word_i,
    output logic     [XLEN-1:0]   data_o
);

    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;

    // Halfword lane ignores the low offset bit, so misaligned addresses truncate.
    always_comb begin
        byte_sh = word_i >> {off_i, 3'b000};
        half_sh = word_i >> {off_i[OFF_W-1:1], 4'b0000};
    end

    always_comb begin
        data_o = '0;
        case (kind_i)
            LD_B:    data_o = XLEN'($signed(byte_sh[7:0]));
            LD_BU:   data_o = XLEN'(byte_sh[7:0]);
            LD_H:    data_o = XLEN'($signed(half_sh[15:0]));
            LD_HU:   data_o = XLEN'(half_sh[15:0]);
            LD_W:    data_o = XLEN'($signed(word_i[31:0]));
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load alignment, write-back data select, valid-gated
// write enables and a retired-instruction counter. State updates on the falling edge.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int CNT_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             bubble_i,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [5:0]       op_i,
    input  logic [5:0]       func_i,
    input  logic [RAW-1:0]   rd_i,
    input  logic [RAW-1:0]   rw_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    input  logic [XLEN-1:0]  result_i,
    input  logic [XLEN-1:0]  result_next_i,
    input  logic             regwr_i,
    input  logic             cpr_wr_i,
    input  logic             hi_wr_i,
    input  logic             lo_wr_i,
    input  logic             hilo_wr_i,
    output logic             wb_valid_o,
    output logic [XLEN-1:0]  wb_pc_o,
    output logic [XLEN-1:0]  wb_result_next_o,
    output logic [5:0]       wb_op_o,
    output logic [5:0]       wb_func_o,
    output logic [RAW-1:0]   wb_rd_o,
    output logic [RAW-1:0]   wb_rw_o,
    output logic [XLEN-1:0]  wb_wdata_o,
    output logic             wb_memtoreg_o,
    output logic             wb_regwr_o,
    output logic             wb_cpr_wr_o,
    output logic             wb_hi_wr_o,
    output logic             wb_lo_wr_o,
    output logic             wb_hilo_wr_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam int OFF_W = $clog2(XLEN / 8);

    ld_kind_e        kind;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wdata_in;
    logic            valid_in;

    logic             valid_d,       valid_q;
    logic [XLEN-1:0]  pc_d,          pc_q;
    logic [XLEN-1:0]  result_next_d, result_next_q;
    logic [5:0]       op_d,          op_q;
    logic [5:0]       func_d,        func_q;
    logic [RAW-1:0]   rd_d,          rd_q;
    logic [RAW-1:0]   rw_d,          rw_q;
    logic [XLEN-1:0]  wdata_d,       wdata_q;
    logic             memtoreg_d,    memtoreg_q;
    logic             regwr_d,       regwr_q;
    logic             cpr_wr_d,      cpr_wr_q;
    logic             hi_wr_d,       hi_wr_q;
    logic             lo_wr_d,       lo_wr_q;
    logic             hilo_wr_d,     hilo_wr_q;
    logic [CNT_W-1:0] instret_d,     instret_q;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .kind_i (kind),
        .off_i  (result_i[OFF_W-1:0]),
        .word_i (mem_rdata_i),
        .data_o (load_data)
    );

    always_comb begin
        kind     = load_kind(op_i);
        wdata_in = (kind != LD_NONE) ? load_data : result_i;
        valid_in = valid_i & ~bubble_i;
    end

    // Flush beats stall; a captured entry carries its enables pre-gated by valid.
    always_comb begin
        valid_d       = valid_q;
        pc_d          = pc_q;
        result_next_d = result_next_q;
        op_d          = op_q;
        func_d        = func_q;
        rd_d          = rd_q;
        rw_d          = rw_q;
        wdata_d       = wdata_q;
        memtoreg_d    = memtoreg_q;
        regwr_d       = regwr_q;
        cpr_wr_d      = cpr_wr_q;
        hi_wr_d       = hi_wr_q;
        lo_wr_d       = lo_wr_q;
        hilo_wr_d     = hilo_wr_q;
        if (flush_i) begin
            valid_d       = 1'b0;
            pc_d          = '0;
            result_next_d = '0;
            op_d          = '0;
            func_d        = '0;
            rd_d          = '0;
            rw_d          = '0;
            wdata_d       = '0;
            memtoreg_d    = 1'b0;
            regwr_d       = 1'b0;
            cpr_wr_d      = 1'b0;
            hi_wr_d       = 1'b0;
            lo_wr_d       = 1'b0;
            hilo_wr_d     = 1'b0;
        end else if (!stall_i) begin
            valid_d       = valid_in;
            pc_d          = pc_i;
            result_next_d = result_next_i;
            op_d          = op_i;
            func_d        = func_i;
            rd_d          = rd_i;
            rw_d          = rw_i;
            wdata_d       = wdata_in;
            memtoreg_d    = valid_in & (kind != LD_NONE);
            regwr_d       = valid_in & regwr_i & (rw_i != '0);
            cpr_wr_d      = valid_in & cpr_wr_i;
            hi_wr_d       = valid_in & hi_wr_i;
            lo_wr_d       = valid_in & lo_wr_i;
            hilo_wr_d     = valid_in & hilo_wr_i;
        end
    end

    // The outgoing entry retires as it leaves, even if a flush replaces it.
    always_comb begin
        instret_d = instret_q;
        if (valid_q && !stall_i) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            result_next_q <= '0;
            op_q          <= '0;
            func_q        <= '0;
            rd_q          <= '0;
            rw_q          <= '0;
            wdata_q       <= '0;
            memtoreg_q    <= 1'b0;
            regwr_q       <= 1'b0;
            cpr_wr_q      <= 1'b0;
            hi_wr_q       <= 1'b0;
            lo_wr_q       <= 1'b0;
            hilo_wr_q     <= 1'b0;
            instret_q     <= '0;
        end else begin
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            result_next_q <= result_next_d;
            op_q          <= op_d;
            func_q        <= func_d;
            rd_q          <= rd_d;
            rw_q          <= rw_d;
            wdata_q       <= wdata_d;
            memtoreg_q    <= memtoreg_d;
            regwr_q       <= regwr_d;
            cpr_wr_q      <= cpr_wr_d;
            hi_wr_q       <= hi_wr_d;
            lo_wr_q       <= lo_wr_d;
            hilo_wr_q     <= hilo_wr_d;
            instret_q     <= instret_d;
        end
    end

    always_comb begin
        wb_valid_o       = valid_q;
        wb_pc_o          = pc_q;
        wb_result_next_o = result_next_q;
        wb_op_o          = op_q;
        wb_func_o        = func_q;
        wb_rd_o          = rd_q;
        wb_rw_o          = rw_q;
        wb_wdata_o       = wdata_q;
        wb_memtoreg_o    = memtoreg_q;
        wb_regwr_o       = regwr_q;
        wb_cpr_wr_o      = cpr_wr_q;
        wb_hi_wr_o       = hi_wr_q;
        wb_lo_wr_o       = lo_wr_q;
        wb_hilo_wr_o     = hilo_wr_q;
        instret_o        = instret_q;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table with scoreboard plus
// hand-written reset, stall, flush and counter-wrap sequences.
module tb_mem_wb_stage;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall_i, flush_i, bubble_i, valid_i;
    logic [XLEN-1:0] pc_i, mem_rdata_i, result_i, result_next_i;
    logic [5:0]      op_i, func_i;
    logic [RAW-1:0]  rd_i, rw_i;
    logic            regwr_i, cpr_wr_i, hi_wr_i, lo_wr_i, hilo_wr_i;

    logic            wb_valid_o, wb_memtoreg_o, wb_regwr_o, wb_cpr_wr_o;
    logic            wb_hi_wr_o, wb_lo_wr_o, wb_hilo_wr_o;
    logic [XLEN-1:0] wb_pc_o, wb_result_next_o, wb_wdata_o;
    logic [5:0]      wb_op_o, wb_func_o;
    logic [RAW-1:0]  wb_rd_o, wb_rw_o;
    logic [47:0]     instret_o;

    logic            w2_valid, w2_memtoreg, w2_regwr, w2_cpr, w2_hi, w2_lo, w2_hilo;
    logic [XLEN-1:0] w2_pc, w2_rn, w2_wdata;
    logic [5:0]      w2_op, w2_func;
    logic [RAW-1:0]  w2_rd, w2_rw;
    logic [3:0]      instret2;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(XLEN), .RAW(RAW), .CNT_W(48)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .bubble_i(bubble_i), .valid_i(valid_i), .pc_i(pc_i), .op_i(op_i),
        .func_i(func_i), .rd_i(rd_i), .rw_i(rw_i), .mem_rdata_i(mem_rdata_i),
        .result_i(result_i), .result_next_i(result_next_i), .regwr_i(regwr_i),
        .cpr_wr_i(cpr_wr_i), .hi_wr_i(hi_wr_i), .lo_wr_i(lo_wr_i),
        .hilo_wr_i(hilo_wr_i), .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o),
        .wb_result_next_o(wb_result_next_o), .wb_op_o(wb_op_o),
        .wb_func_o(wb_func_o), .wb_rd_o(wb_rd_o), .wb_rw_o(wb_rw_o),
        .wb_wdata_o(wb_wdata_o), .wb_memtoreg_o(wb_memtoreg_o),
        .wb_regwr_o(wb_regwr_o), .wb_cpr_wr_o(wb_cpr_wr_o),
        .wb_hi_wr_o(wb_hi_wr_o), .wb_lo_wr_o(wb_lo_wr_o),
        .wb_hilo_wr_o(wb_hilo_wr_o), .instret_o(instret_o)
    );

    mem_wb_stage #(.XLEN(XLEN), .RAW(RAW), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .bubble_i(bubble_i), .valid_i(valid_i), .pc_i(pc_i), .op_i(op_i),
        .func_i(func_i), .rd_i(rd_i), .rw_i(rw_i), .mem_rdata_i(mem_rdata_i),
        .result_i(result_i), .result_next_i(result_next_i), .regwr_i(regwr_i),
        .cpr_wr_i(cpr_wr_i), .hi_wr_i(hi_wr_i), .lo_wr_i(lo_wr_i),
        .hilo_wr_i(hilo_wr_i), .wb_valid_o(w2_valid), .wb_pc_o(w2_pc),
        .wb_result_next_o(w2_rn), .wb_op_o(w2_op), .wb_func_o(w2_func),
        .wb_rd_o(w2_rd), .wb_rw_o(w2_rw), .wb_wdata_o(w2_wdata),
        .wb_memtoreg_o(w2_memtoreg), .wb_regwr_o(w2_regwr), .wb_cpr_wr_o(w2_cpr),
        .wb_hi_wr_o(w2_hi), .wb_lo_wr_o(w2_lo), .wb_hilo_wr_o(w2_hilo),
        .instret_o(instret2)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_valid  = 1'b0;
    logic [63:0] m_cnt    = '0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [31:0] result;
        logic [4:0]  rw;
        logic        bubble;
        logic        exp_valid;
        logic [31:0] exp_wdata;
        logic        exp_memtoreg;
        logic        exp_regwr;
        logic        exp_hi;
    } vec_t;

    vec_t vecs[13];
    vec_t sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One falling edge; the bench's own model of valid and retire count follows it.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (m_valid && !stall_i) m_cnt = m_cnt + 64'd1;
            if (flush_i) m_valid = 1'b0;
            else if (!stall_i) m_valid = valid_i & ~bubble_i;
        end
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 0; flush_i = 0; bubble_i = 0; valid_i = 0;
        pc_i = '0; op_i = '0; func_i = '0; rd_i = '0; rw_i = '0;
        mem_rdata_i = '0; result_i = '0; result_next_i = '0;
        regwr_i = 0; cpr_wr_i = 0; hi_wr_i = 0; lo_wr_i = 0; hilo_wr_i = 0;
    endtask

    task automatic drive_valid(input logic [5:0] op, input logic [31:0] pc);
        valid_i = 1; bubble_i = 0; op_i = op; func_i = 6'b100001;
        pc_i = pc; rw_i = 5'd3; rd_i = 5'd3; regwr_i = 1;
        result_i = 32'h0000_0100; mem_rdata_i = 32'hCAFE_F00D;
    endtask

    initial begin
        vecs[0]  = '{"lb_off3",   6'b100000, 6'd0, 32'h3, 5'd5, 1'b0, 1'b1, 32'hFFFFFF80, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{"lbu_off3",  6'b100100, 6'd0, 32'h3, 5'd5, 1'b0, 1'b1, 32'h00000080, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{"lh_off2",   6'b100001, 6'd0, 32'h2, 5'd5, 1'b0, 1'b1, 32'hFFFF80FF, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{"lhu_off0",  6'b100101, 6'd0, 32'h0, 5'd5, 1'b0, 1'b1, 32'h00007F01, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{"addu",      6'b000000, 6'b100001, 32'h1234, 5'd5, 1'b0, 1'b1, 32'h00001234, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{"lw_off0",   6'b100011, 6'd0, 32'h10, 5'd5, 1'b0, 1'b1, 32'h80FF7F01, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{"lb_off0",   6'b100000, 6'd0, 32'h0, 5'd5, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{"lb_off1",   6'b100000, 6'd0, 32'h1, 5'd5, 1'b0, 1'b1, 32'h0000007F, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{"lh_off1",   6'b100001, 6'd0, 32'h1, 5'd5, 1'b0, 1'b1, 32'h00007F01, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{"lhu_off2",  6'b100101, 6'd0, 32'h2, 5'd5, 1'b0, 1'b1, 32'h000080FF, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{"lbu_off2",  6'b100100, 6'd0, 32'h2, 5'd5, 1'b0, 1'b1, 32'h000000FF, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{"bubble",    6'b000000, 6'b100001, 32'h55, 5'd5, 1'b1, 1'b0, 32'h00000055, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"rw_zero",   6'b000000, 6'b100001, 32'h77, 5'd0, 1'b0, 1'b1, 32'h00000077, 1'b0, 1'b0, 1'b1};

        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk("por_valid", wb_valid_o, 0);
        chk("por_instret", instret_o, 0);
        rst_n = 1'b1;

        // Table-driven alignment and gating vectors through the scoreboard.
        for (int i = 0; i < 13; i++) begin
            vec_t v;
            vec_t e;
            v = vecs[i];
            valid_i = 1; bubble_i = v.bubble; op_i = v.op; func_i = v.func;
            result_i = v.result; rw_i = v.rw; rd_i = 5'd9; mem_rdata_i = 32'h80FF7F01;
            regwr_i = 1; hi_wr_i = v.bubble | (v.rw == 0); pc_i = 32'h1000 + i * 4;
            sb_q.push_back(v);
            tick();
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_valid"}, wb_valid_o, e.exp_valid);
                chk({e.name, "_wdata"}, wb_wdata_o, e.exp_wdata);
                chk({e.name, "_memtoreg"}, wb_memtoreg_o, e.exp_memtoreg);
                chk({e.name, "_regwr"}, wb_regwr_o, e.exp_regwr);
                chk({e.name, "_hi"}, wb_hi_wr_o, e.exp_hi);
                chk({e.name, "_instret"}, instret_o, m_cnt[47:0]);
            end
        end

        // Stall: entry held while inputs change, no retire.
        clear_inputs();
        drive_valid(6'b000000, 32'h0040_0010);
        tick();
        chk("stall_capture_pc", wb_pc_o, 32'h0040_0010);
        for (int i = 0; i < 3; i++) begin
            stall_i = 1; pc_i = 32'h0050_0000 + i; rw_i = 5'd7;
            tick();
            chk("stall_pc", wb_pc_o, 32'h0040_0010);
            chk("stall_valid", wb_valid_o, 1);
            chk("stall_regwr", wb_regwr_o, 1);
            chk("stall_instret", instret_o, m_cnt[47:0]);
        end
        stall_i = 0;
        tick();
        chk("unstall_pc", wb_pc_o, 32'h0050_0002);
        chk("unstall_instret", instret_o, m_cnt[47:0]);

        // Flush and stall together: flush wins.
        drive_valid(6'b000000, 32'h0000_2000);
        rw_i = 5'd8; cpr_wr_i = 1; hi_wr_i = 1; lo_wr_i = 1; hilo_wr_i = 1;
        tick();
        chk("preflush_valid", wb_valid_o, 1);
        chk("preflush_hilo", wb_hilo_wr_o, 1);
        flush_i = 1; stall_i = 1;
        tick();
        chk("flush_valid", wb_valid_o, 0);
        chk("flush_en", {wb_regwr_o, wb_cpr_wr_o, wb_hi_wr_o, wb_lo_wr_o, wb_hilo_wr_o, wb_memtoreg_o}, 0);
        chk("flush_pc", wb_pc_o, 0);
        chk("flush_instret", instret_o, m_cnt[47:0]);
        clear_inputs();

        // Asynchronous reset in the middle of valid traffic.
        drive_valid(6'b100011, 32'h0000_3000);
        tick();
        tick();
        chk("prerst_valid", wb_valid_o, 1);
        rst_n = 1'b0;
        #1;
        m_valid = 0; m_cnt = '0;
        chk("rst_valid", wb_valid_o, 0);
        chk("rst_pc", wb_pc_o, 0);
        chk("rst_wdata", wb_wdata_o, 0);
        chk("rst_en", {wb_regwr_o, wb_memtoreg_o, wb_rw_o}, 0);
        chk("rst_instret", instret_o, 0);
        stall_i = 1; flush_i = 1;
        tick();
        chk("rst_hold_valid", wb_valid_o, 0);
        chk("rst_hold_instret", instret_o, 0);
        stall_i = 0; flush_i = 0;
        rst_n = 1'b1;
        tick();
        chk("postrst_lw_valid", wb_valid_o, 1);
        chk("postrst_lw_memtoreg", wb_memtoreg_o, 1);

        // Counter wrap: 17 entries retire into a 4-bit counter, then bubbles.
        rst_n = 1'b0;
        #1;
        m_valid = 0; m_cnt = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_valid(6'b000000, 32'h4000 + i * 4);
            tick();
        end
        valid_i = 1; bubble_i = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("wrap_instret4", instret2, 4'd1);
        chk("wrap_instret48", instret_o, 48'd17);
        chk("wrap_model", instret2, m_cnt[3:0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
